// File: rtl/rob_pkg.sv
// Shared sizing, entry layout and controller states for the reorder buffer.
// Any module that touches ROB tags or entries imports this package.
package rob_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int NUM_PREGS   = 64;
    localparam int NUM_AREGS   = 32;

    localparam int IW = $clog2(ROB_ENTRIES);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int AW = $clog2(NUM_AREGS);

    // Entry count in pointer width, so num_free can be computed without a width change
    localparam logic [IW:0] ROB_COUNT = ROB_ENTRIES[IW:0];

    typedef struct packed {
        logic          valid;
        logic          busy;
        logic          exception;
        logic          macroop_begin;
        logic          macroop_end;
        logic [AW-1:0] areg;
        logic [PW-1:0] preg;
        logic [PW-1:0] prev_preg;
    } rob_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit ROB pointer: the low bits index an entry, and the MSB flips on every lap
// so that full and empty can be told apart.
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer sequencing: allocates entries in order, marks them complete at
// writeback, and retires them in order (or flushes when the head entry faulted).
module rob_ctrl
    import rob_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    input  logic [AW-1:0] alloc_areg,
    input  logic [PW-1:0] alloc_preg,
    input  logic [PW-1:0] alloc_prev_preg,
    input  logic          alloc_mbegin,
    input  logic          alloc_mend,
    output logic [IW-1:0] alloc_idx,
    input  logic          wb_valid,
    input  logic [IW-1:0] wb_idx,
    input  logic          wb_exception,
    output logic          commit_valid,
    output logic [AW-1:0] commit_areg,
    output logic [PW-1:0] commit_preg,
    output logic          free_valid,
    output logic [PW-1:0] free_preg,
    output logic          flush,
    output logic [IW:0]   num_free,
    output logic          interruptible
);

    rob_entry_t r_entries [ROB_ENTRIES];
    rob_state_t r_state;
    logic       r_flush;

    logic [IW:0] w_head;
    logic [IW:0] w_tail;
    logic [IW:0] w_used;
    rob_entry_t  w_head_entry;
    logic        w_run;
    logic        w_empty;
    logic        w_full;
    logic        w_head_done;
    logic        w_commit;
    logic        w_take_exc;
    logic        w_alloc_fire;
    logic        w_clear;
    logic        w_unused_mend;

    rob_ptr #(.W(IW + 1)) u_head_ptr (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_commit),
        .i_clear (w_clear),
        .o_ptr   (w_head)
    );

    rob_ptr #(.W(IW + 1)) u_tail_ptr (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_alloc_fire),
        .i_clear (w_clear),
        .o_ptr   (w_tail)
    );

    assign w_run        = (r_state == RUN);
    assign w_clear      = (r_state == FLUSH);
    assign w_head_entry = r_entries[w_head[IW-1:0]];
    assign w_empty      = (w_head == w_tail);
    assign w_full       = (w_head[IW-1:0] == w_tail[IW-1:0]) && (w_head[IW] != w_tail[IW]);
    assign w_used       = w_tail - w_head;

    // The head decision is gated by RUN so a faulted head cannot retire during the flush cycle
    assign w_head_done  = w_run && w_head_entry.valid && !w_head_entry.busy;
    assign w_commit     = w_head_done && !w_head_entry.exception;
    assign w_take_exc   = w_head_done && w_head_entry.exception;
    assign w_alloc_fire = alloc_valid && alloc_ready;

    assign alloc_ready   = !w_full && w_run;
    assign alloc_idx     = w_tail[IW-1:0];
    assign num_free      = ROB_COUNT - w_used;
    assign commit_valid  = w_commit;
    assign commit_areg   = w_head_entry.areg;
    assign commit_preg   = w_head_entry.preg;
    assign free_valid    = w_commit;
    assign free_preg     = w_head_entry.prev_preg;
    assign flush         = r_flush;
    assign interruptible = w_empty || (w_head_entry.valid && w_head_entry.macroop_begin);

    // Macro-op end is recorded for future use but nothing consumes it yet
    assign w_unused_mend = w_head_entry.macroop_end;

    // Writeback and commit never hit the same entry: one needs busy set, the other clear
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                r_entries[i].valid     <= 1'b0;
                r_entries[i].busy      <= 1'b0;
                r_entries[i].exception <= 1'b0;
            end
        end else begin
            if (wb_valid && r_entries[wb_idx].valid && r_entries[wb_idx].busy) begin
                r_entries[wb_idx].busy      <= 1'b0;
                r_entries[wb_idx].exception <= wb_exception;
            end
            if (w_commit) begin
                r_entries[w_head[IW-1:0]].valid <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_entries[w_tail[IW-1:0]] <= '{
                    valid:         1'b1,
                    busy:          1'b1,
                    exception:     1'b0,
                    macroop_begin: alloc_mbegin,
                    macroop_end:   alloc_mend,
                    areg:          alloc_areg,
                    preg:          alloc_preg,
                    prev_preg:     alloc_prev_preg
                };
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_flush <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_take_exc) begin
                        r_state <= FLUSH;
                        r_flush <= 1'b1;
                    end
                end
                FLUSH: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: directed scenarios plus random traffic, all checked against
// an in-order queue model of the in-flight ops.
module tb_rob_ctrl;
    import rob_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [AW-1:0] alloc_areg;
    logic [PW-1:0] alloc_preg;
    logic [PW-1:0] alloc_prev_preg;
    logic          alloc_mbegin;
    logic          alloc_mend;
    logic [IW-1:0] alloc_idx;
    logic          wb_valid;
    logic [IW-1:0] wb_idx;
    logic          wb_exception;
    logic          commit_valid;
    logic [AW-1:0] commit_areg;
    logic [PW-1:0] commit_preg;
    logic          free_valid;
    logic [PW-1:0] free_preg;
    logic          flush;
    logic [IW:0]   num_free;
    logic          interruptible;

    always #5 clk = ~clk;

    rob_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_areg      (alloc_areg),
        .alloc_preg      (alloc_preg),
        .alloc_prev_preg (alloc_prev_preg),
        .alloc_mbegin    (alloc_mbegin),
        .alloc_mend      (alloc_mend),
        .alloc_idx       (alloc_idx),
        .wb_valid        (wb_valid),
        .wb_idx          (wb_idx),
        .wb_exception    (wb_exception),
        .commit_valid    (commit_valid),
        .commit_areg     (commit_areg),
        .commit_preg     (commit_preg),
        .free_valid      (free_valid),
        .free_preg       (free_preg),
        .flush           (flush),
        .num_free        (num_free),
        .interruptible   (interruptible)
    );

    // One in-flight op as the program sees it, oldest at the front of the queue
    typedef struct {
        int tag;
        int areg;
        int preg;
        int prev;
        bit mbegin;
        bit done;
        bit exc;
    } modelOp_t;

    modelOp_t modelQ[$];
    int       nextTag;
    bit       modelFlushing;
    int       checks;
    int       errors;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", name, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then advance the model
    task automatic applyStimulus(input bit rst, input bit av, input int areg, input int preg,
                                 input int prev, input bit mb, input bit wv, input int widx,
                                 input bit wexc, input bit chk);
        bit       expReady;
        bit       expCommit;
        bit       expExc;
        bit       expIntr;
        int       expFree;
        modelOp_t op;
        @(negedge clk);
        reset           = rst;
        alloc_valid     = av;
        alloc_areg      = AW'(areg);
        alloc_preg      = PW'(preg);
        alloc_prev_preg = PW'(prev);
        alloc_mbegin    = mb;
        alloc_mend      = 1'($urandom_range(0, 1));
        wb_valid        = wv;
        wb_idx          = IW'(widx);
        wb_exception    = wexc;
        #1;
        expReady  = !modelFlushing && (modelQ.size() < ROB_ENTRIES);
        expCommit = !modelFlushing && (modelQ.size() > 0) && modelQ[0].done && !modelQ[0].exc;
        expExc    = !modelFlushing && (modelQ.size() > 0) && modelQ[0].done && modelQ[0].exc;
        expIntr   = (modelQ.size() == 0) || modelQ[0].mbegin;
        expFree   = ROB_ENTRIES - modelQ.size();
        if (chk) begin
            checkOutput("alloc_ready", 32'(alloc_ready), 32'(expReady));
            checkOutput("alloc_idx", 32'(alloc_idx), nextTag);
            checkOutput("num_free", 32'(num_free), expFree);
            checkOutput("interruptible", 32'(interruptible), 32'(expIntr));
            checkOutput("flush", 32'(flush), 32'(modelFlushing));
            checkOutput("commit_valid", 32'(commit_valid), 32'(expCommit));
            checkOutput("free_valid", 32'(free_valid), 32'(expCommit));
            if (expCommit) begin
                checkOutput("commit_areg", 32'(commit_areg), modelQ[0].areg);
                checkOutput("commit_preg", 32'(commit_preg), modelQ[0].preg);
                checkOutput("free_preg", 32'(free_preg), modelQ[0].prev);
            end
        end
        if (rst || modelFlushing) begin
            modelQ.delete();
            nextTag       = 0;
            modelFlushing = 1'b0;
        end else begin
            if (wv) begin
                foreach (modelQ[i]) begin
                    if (modelQ[i].tag == widx && !modelQ[i].done) begin
                        modelQ[i].done = 1'b1;
                        modelQ[i].exc  = wexc;
                    end
                end
            end
            if (expCommit) void'(modelQ.pop_front());
            if (expExc) modelFlushing = 1'b1;
            if (av && expReady) begin
                op = '{tag: nextTag, areg: areg % NUM_AREGS, preg: preg % NUM_PREGS,
                       prev: prev % NUM_PREGS, mbegin: mb, done: 1'b0, exc: 1'b0};
                modelQ.push_back(op);
                nextTag = (nextTag + 1) % ROB_ENTRIES;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic allocOp(input int areg, input int preg, input int prev, input bit mb);
        applyStimulus(0, 1, areg, preg, prev, mb, 0, 0, 0, 1);
    endtask

    task automatic wbOp(input int idx, input bit exc);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, idx, exc, 1);
    endtask

    initial begin
        int widx;
        checks        = 0;
        errors        = 0;
        nextTag       = 0;
        modelFlushing = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Fill to full, then one more request that must be refused
        for (int i = 0; i <= ROB_ENTRIES; i++) allocOp(i, 32 + i, i, i[0]);
        idle(1);

        // Out-of-order completion, in-order retirement
        doReset();
        for (int i = 0; i < 3; i++) allocOp(i, 32 + i, i, 1'b1);
        wbOp(2, 0);
        wbOp(0, 0);
        idle(1);
        wbOp(1, 0);
        idle(3);

        // Wrap the tail past the end of the array and fill again
        doReset();
        for (int i = 0; i < ROB_ENTRIES; i++) allocOp(i, 32 + i, i, 1'b0);
        for (int i = 0; i < 4; i++) wbOp(i, 0);
        idle(3);
        for (int i = 0; i < 5; i++) allocOp(20 + i, 48 + i, 10 + i, 1'b1);
        idle(1);

        // Faulting head: one flush cycle, late writeback ignored, buffer empty afterwards
        doReset();
        for (int i = 0; i < 3; i++) allocOp(i, 40 + i, i, 1'b1);
        wbOp(0, 1);
        idle(1);
        wbOp(1, 0);
        idle(2);

        // Reset landing on the flush cycle, and reset racing an allocation
        allocOp(5, 50, 5, 1'b1);
        wbOp(0, 1);
        idle(1);
        doReset();
        idle(1);
        applyStimulus(1, 1, 7, 55, 7, 1, 0, 0, 0, 1);
        idle(2);

        // Random traffic with occasional faults and resets
        for (int n = 0; n < 3000; n++) begin
            if (modelQ.size() > 0 && $urandom_range(0, 99) < 80)
                widx = modelQ[$urandom_range(0, modelQ.size() - 1)].tag;
            else
                widx = $urandom_range(0, ROB_ENTRIES - 1);
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 99) < 60,
                          $urandom_range(0, NUM_AREGS - 1),
                          $urandom_range(0, NUM_PREGS - 1),
                          $urandom_range(0, NUM_PREGS - 1),
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 99) < 50,
                          widx,
                          $urandom_range(0, 99) < 4,
                          1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
